// File: rtl/regfile_dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_dbg_pkg
//  Description : Shared types and sizes for the register-file dump path.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_dbg_pkg;

    localparam int REG_IDX_W     = 5;
    localparam int XLEN          = 32;
    localparam int BYTES_PER_REG = 4;
    localparam int BYTE_W        = 8;
    localparam int BYTE_CNT_W    = $clog2(BYTES_PER_REG);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } dump_state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_dump_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_dump_ctrl_if
//  Description : Read-port-A arbitration signals and the byte stream to UART TX.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_dump_ctrl_if;
    import regfile_dbg_pkg::*;

    logic                 core_rd_req;
    logic                 rd_grant;
    logic [REG_IDX_W-1:0] rd_addr;
    logic [XLEN-1:0]      rf_rdData;
    logic [BYTE_W-1:0]    tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    // Dump controller side
    modport master (
        input  core_rd_req,
        input  rf_rdData,
        input  tx_ready,
        output rd_grant,
        output rd_addr,
        output tx_data,
        output tx_valid
    );

    // Regfile mux / UART side
    modport slave (
        output core_rd_req,
        output rf_rdData,
        output tx_ready,
        input  rd_grant,
        input  rd_addr,
        input  tx_data,
        input  tx_valid
    );

endinterface
`default_nettype wire

// File: rtl/regfile_dump_ctrl_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : word_serializer
//  Description : Loads a 32-bit word and emits it as 4 bytes on a valid/ready
//                stream; flags the handshake that accepts the final byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_serializer
    import regfile_dbg_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_load,
    input  wire logic [XLEN-1:0]   i_word,
    output logic      [BYTE_W-1:0] o_byte,
    output logic                   o_valid,
    input  wire logic              i_ready,
    output logic                   o_lastAccept
);

    localparam logic [BYTE_CNT_W-1:0] c_LAST_BYTE = BYTE_CNT_W'(BYTES_PER_REG - 1);

    logic [XLEN-1:0]       r_shift;
    logic [BYTE_CNT_W-1:0] r_count;
    logic                  r_valid;
    logic [XLEN-1:0]       w_shifted;
    logic                  w_accept;

    // Byte order decides which end is emitted and which way the word drains
    if (LSB_FIRST) begin : g_lsb_first
        assign o_byte    = r_shift[BYTE_W-1:0];
        assign w_shifted = {{BYTE_W{1'b0}}, r_shift[XLEN-1:BYTE_W]};
    end else begin : g_msb_first
        assign o_byte    = r_shift[XLEN-1:XLEN-BYTE_W];
        assign w_shifted = {r_shift[XLEN-BYTE_W-1:0], {BYTE_W{1'b0}}};
    end

    assign w_accept     = r_valid && i_ready;
    assign o_valid      = r_valid;
    assign o_lastAccept = w_accept && (r_count == c_LAST_BYTE);

    // Load the word, then drain one byte per accepted handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_word;
            r_count <= '0;
            r_valid <= 1'b1;
        end else if (w_accept) begin
            r_shift <= w_shifted;
            r_count <= r_count + 1'b1;
            if (r_count == c_LAST_BYTE) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_dump_ctrl
//  Description : Reads registers FIRST_REG..LAST_REG through the shared read
//                port (core has priority) and streams them as bytes to UART TX.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_dump_ctrl
    import regfile_dbg_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter bit LSB_FIRST = 1'b1
) (
    input  wire logic           clk,
    input  wire logic           reset,
    input  wire logic           start,
    output logic                busy,
    output logic                done,
    regfile_dump_ctrl_if.master bus
);

    localparam logic [REG_IDX_W-1:0] c_FIRST = REG_IDX_W'(FIRST_REG);
    localparam logic [REG_IDX_W-1:0] c_LAST  = REG_IDX_W'(LAST_REG);

    dump_state_t          r_state;
    logic [REG_IDX_W-1:0] r_rdAddr;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_load;
    logic                 w_lastAccept;

    // Grant only while requesting and the core leaves the port free; reset
    // removes it in the same cycle so the mux returns to the core at once.
    assign bus.rd_grant = (r_state == ST_REQ) && !bus.core_rd_req && !reset;
    assign bus.rd_addr  = r_rdAddr;
    assign busy         = r_busy;
    assign done         = r_done;

    // Read data arrives the cycle after the granted address edge
    assign w_load = (r_state == ST_WAIT);

    word_serializer #(
        .LSB_FIRST    (LSB_FIRST)
    ) u_serializer (
        .clk          (clk),
        .rst          (reset),
        .i_load       (w_load),
        .i_word       (bus.rf_rdData),
        .o_byte       (bus.tx_data),
        .o_valid      (bus.tx_valid),
        .i_ready      (bus.tx_ready),
        .o_lastAccept (w_lastAccept)
    );

    // Dump sequencer: request, capture, serialise, advance or finish
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_rdAddr <= c_FIRST;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_REQ;
                        r_rdAddr <= c_FIRST;
                        r_busy   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (!bus.core_rd_req) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_lastAccept) begin
                        // Check the end before incrementing so the index never wraps
                        if (r_rdAddr == c_LAST) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_rdAddr <= r_rdAddr + 1'b1;
                            r_state  <= ST_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_dump_ctrl
//  Description : Scoreboard bench for regfile_dump_ctrl (default and a
//                single-register MSB-first instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_ctrl;

    logic clk;
    logic reset;
    logic start0, start1;
    logic busy0, busy1, done0, done1;

    regfile_dump_ctrl_if bus0();
    regfile_dump_ctrl_if bus1();

    regfile_dump_ctrl dut0 (
        .clk   (clk),
        .reset (reset),
        .start (start0),
        .busy  (busy0),
        .done  (done0),
        .bus   (bus0)
    );

    regfile_dump_ctrl #(
        .FIRST_REG (5),
        .LAST_REG  (5),
        .LSB_FIRST (1'b0)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .start (start1),
        .busy  (busy1),
        .done  (done1),
        .bus   (bus1)
    );

    int nVec = 0;
    int nErr = 0;
    int cyc  = 0;

    logic [7:0]  expQ0[$];
    logic [7:0]  expQ1[$];
    logic [7:0]  expByte0, expByte1;
    logic [31:0] rfMem0 [32];

    int   rxCount0 = 0, rxCount1 = 0;
    int   doneCount0 = 0, doneCount1 = 0;
    int   doneCyc0 = 0;
    logic busyAtDone0 = 1'b0;
    logic prevStall0 = 1'b0;
    logic [7:0] prevData0 = 8'h00;
    logic readyToggle = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous read-port models
    always @(posedge clk) bus0.rf_rdData <= rfMem0[bus0.rd_addr];
    always @(posedge clk) bus1.rf_rdData <= (bus1.rd_addr == 5'd5) ? 32'h1234_5678 : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pushDump0();
        logic [31:0] v;
        for (int r = 0; r < 32; r++) begin
            v = (r == 0) ? 32'h0 : 32'hA500_0000 + 32'(r);
            for (int b = 0; b < 4; b++) expQ0.push_back(v[8*b +: 8]);
        end
    endtask

    task automatic pulseStart0();
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
    endtask

    task automatic waitDone0(input int target, input int limit, input string name);
        for (int i = 0; i < limit && doneCount0 < target; i++) tick();
        chk(name, 32'(doneCount0), 32'(target));
    endtask

    task automatic endOfDump0(input string name);
        tick();
        chk({name, " busy after done"}, 32'(busy0), 32'd0);
        chk({name, " byte count"}, 32'(rxCount0), 32'd128);
        chk({name, " queue empty"}, 32'(expQ0.size()), 32'd0);
    endtask

    // Monitor/scoreboard for the default instance
    always @(negedge clk) begin
        if (reset) begin
            prevStall0 = 1'b0;
        end else begin
            if (prevStall0) begin
                chk("dut0 hold valid", 32'(bus0.tx_valid), 32'd1);
                chk("dut0 hold data", 32'(bus0.tx_data), 32'(prevData0));
            end
            if (bus0.tx_valid && bus0.tx_ready) begin
                rxCount0++;
                if (expQ0.size() == 0) begin
                    nVec++;
                    nErr++;
                    $display("FAIL dut0 extra byte: got %02h, expected none", bus0.tx_data);
                end else begin
                    expByte0 = expQ0.pop_front();
                    chk("dut0 byte", 32'(bus0.tx_data), 32'(expByte0));
                end
            end
            prevStall0 = bus0.tx_valid && !bus0.tx_ready;
            prevData0  = bus0.tx_data;
            if (done0) begin
                doneCount0++;
                doneCyc0    = cyc;
                busyAtDone0 = busy0;
            end
        end
    end

    // Monitor/scoreboard for the single-register instance
    always @(negedge clk) begin
        if (!reset) begin
            if (bus1.tx_valid && bus1.tx_ready) begin
                rxCount1++;
                if (expQ1.size() == 0) begin
                    nVec++;
                    nErr++;
                    $display("FAIL dut1 extra byte: got %02h, expected none", bus1.tx_data);
                end else begin
                    expByte1 = expQ1.pop_front();
                    chk("dut1 byte", 32'(bus1.tx_data), 32'(expByte1));
                end
            end
            if (done1) doneCount1++;
        end
    end

    // UART ready: tied high or alternating 1-0-1-0
    initial begin
        bus0.tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (readyToggle) bus0.tx_ready = !bus0.tx_ready;
            else             bus0.tx_ready = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        int target;
        for (int r = 0; r < 32; r++) rfMem0[r] = (r == 0) ? 32'h0 : 32'hA500_0000 + 32'(r);
        reset = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        bus0.core_rd_req = 1'b0;
        bus1.core_rd_req = 1'b0;
        bus1.tx_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        tick();
        chk("rst busy", 32'(busy0), 32'd0);
        chk("rst done", 32'(done0), 32'd0);
        chk("rst rd_grant", 32'(bus0.rd_grant), 32'd0);
        chk("rst rd_addr", 32'(bus0.rd_addr), 32'd0);
        chk("rst tx_valid", 32'(bus0.tx_valid), 32'd0);
        chk("rst tx_data", 32'(bus0.tx_data), 32'd0);
        chk("rst dut1 rd_addr", 32'(bus1.rd_addr), 32'd5);
        @(posedge clk); #1 reset = 1'b0;

        // Plain dump with tx_ready high: 192 cycles from first REQ to done
        pushDump0();
        pulseStart0();
        c0 = -1;
        for (int i = 0; i < 10 && c0 < 0; i++) begin
            tick();
            if (bus0.rd_grant) c0 = cyc;
        end
        chk("first grant seen", 32'(c0 >= 0), 32'd1);
        waitDone0(1, 400, "plain done");
        chk("plain done timing", 32'(doneCyc0 - c0), 32'd192);
        chk("busy during done", 32'(busyAtDone0), 32'd1);
        endOfDump0("plain");

        // Same dump with tx_ready alternating
        rxCount0 = 0;
        readyToggle = 1'b1;
        pushDump0();
        pulseStart0();
        waitDone0(2, 1000, "toggle done");
        endOfDump0("toggle");
        @(posedge clk); #1 readyToggle = 1'b0;

        // Core holds the read port during the request for x7
        rxCount0 = 0;
        pushDump0();
        pulseStart0();
        for (int i = 0; i < 200 && !(bus0.rd_addr == 5'd6 && bus0.tx_valid); i++) tick();
        @(posedge clk); #1 bus0.core_rd_req = 1'b1;
        for (int i = 0; i < 20 && bus0.rd_addr != 5'd7; i++) tick();
        chk("contention addr", 32'(bus0.rd_addr), 32'd7);
        for (int i = 0; i < 10; i++) begin
            chk("contention grant", 32'(bus0.rd_grant), 32'd0);
            chk("contention tx_valid", 32'(bus0.tx_valid), 32'd0);
            tick();
        end
        @(posedge clk); #1 bus0.core_rd_req = 1'b0;
        waitDone0(3, 400, "contention done");
        endOfDump0("contention");

        // Second start while busy is ignored
        rxCount0 = 0;
        pushDump0();
        pulseStart0();
        repeat (50) @(posedge clk);
        #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        waitDone0(4, 400, "restart done");
        repeat (30) tick();
        chk("restart done count", 32'(doneCount0), 32'd4);
        chk("restart byte count", 32'(rxCount0), 32'd128);
        chk("restart busy", 32'(busy0), 32'd0);

        // Reset after 9 bytes, then a full dump
        rxCount0 = 0;
        pushDump0();
        pulseStart0();
        for (int i = 0; i < 100 && rxCount0 < 9; i++) tick();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        tick();
        chk("midreset tx_valid", 32'(bus0.tx_valid), 32'd0);
        chk("midreset busy", 32'(busy0), 32'd0);
        chk("midreset rd_grant", 32'(bus0.rd_grant), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        expQ0.delete();
        rxCount0 = 0;
        target = doneCount0 + 1;
        pushDump0();
        pulseStart0();
        waitDone0(target, 400, "post-reset done");
        endOfDump0("post-reset");

        // Single register, MSB first
        expQ1.push_back(8'h12);
        expQ1.push_back(8'h34);
        expQ1.push_back(8'h56);
        expQ1.push_back(8'h78);
        rxCount1 = 0;
        target = doneCount1 + 1;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        for (int i = 0; i < 40 && doneCount1 < target; i++) tick();
        chk("dut1 done", 32'(doneCount1), 32'(target));
        chk("dut1 byte count", 32'(rxCount1), 32'd4);
        chk("dut1 queue empty", 32'(expQ1.size()), 32'd0);
        tick();
        chk("dut1 busy after done", 32'(busy1), 32'd0);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_dump_ctrl.md
Name: regfile_dump_ctrl

Overview:
- Sequences a full read-out of the 32x32 register file through one synchronous read port, for the host debug link.
- The core keeps priority on the read port. This block only reads in cycles when the core does not.
- Each 32-bit register value is serialised into 4 bytes on a valid/ready byte stream that feeds the UART transmitter.
- Sits between the regfile read-port-A address mux and the UART TX.

Parameters:
- FIRST_REG, 0, index of the first register dumped (0..31)
- LAST_REG, 31, index of the last register dumped (FIRST_REG..31)
- LSB_FIRST, 1, 1 = byte [7:0] is sent first; 0 = byte [31:24] is sent first

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin a dump
- busy  out  1  high from the cycle after an accepted start until the cycle after done
- done  out  1  one-cycle pulse after the last byte is accepted
- core_rd_req  in  1  core needs read port A this cycle (has priority)
- rd_grant  out  1  block owns read port A this cycle; external mux selects rd_addr
- rd_addr  out  5  register index presented to read port A when rd_grant=1
- rf_rdData  in  32  read port A data, valid one cycle after the address edge
- tx_data  out  8  byte to UART TX
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  UART TX accepts the byte this cycle

Behaviour:
- Reset values:
  - busy=0, done=0, rd_grant=0, rd_addr=FIRST_REG, tx_valid=0, tx_data=0
  - state=IDLE; byte counter=0; 32-bit shift register=0
- States: IDLE, REQ, WAIT, SEND, DONE.
- IDLE:
  - start=1 -> REQ; rd_addr loads FIRST_REG.
  - start=0 -> stay.
- REQ:
  - rd_grant = !core_rd_req (combinational).
  - If core_rd_req=0: grant taken this cycle -> WAIT.
  - Else stay in REQ. No timeout; stalls indefinitely under continuous core use.
- WAIT:
  - Capture rf_rdData into the shift register; byte counter=0 -> SEND.
  - rd_grant=0.
- SEND:
  - tx_valid=1; tx_data = low byte (LSB_FIRST=1) or high byte (LSB_FIRST=0) of the shift register.
  - tx_valid and tx_data stay stable until tx_ready=1.
  - On a handshake: shift by 8 toward the emitting end; counter+1.
  - After the 4th handshake:
    - if rd_addr==LAST_REG -> DONE
    - else rd_addr+1 -> REQ
- DONE: done=1 for one cycle; busy=0 the next cycle; -> IDLE.
- Throughput: minimum 6 cycles per register with no contention and tx_ready tied high (REQ, WAIT, 4 SEND cycles). Total bytes = 4*(LAST_REG-FIRST_REG+1); 128 by default.
- start while busy: ignored, with no restart or queueing.
- start in the same cycle as done: ignored.
- reset mid-dump: returns to reset values next cycle.
  - tx_valid drops even without a handshake; a partial stream is acceptable.
  - rd_grant drops immediately.
- rd_addr arithmetic: 5-bit. No wrap occurs because the LAST_REG check comes before the increment.
- Register x0 data is whatever the regfile returns (architecturally 0); no special-casing.
- A core write to the register being read in the same edge as the grant is not ordered by this block. It returns the pre-write value (regfile read-before-write).

Decomposition:
- Shared package regfile_dbg_pkg holds:
  - state enum
  - REG_IDX_W=5, XLEN=32, BYTES_PER_REG=4
- One natural sub-module: word_serializer, a 32-bit to 8-bit valid/ready shifter with a load strobe and a done-after-4 flag.
- FSM, arbitration and address counter stay in the top module.

Test Plan:
- Reset, preload x1..x31 = 0xA5000000+i, start pulse, tx_ready=1.
  - 128 bytes.
  - First four: 00 00 00 00 (x0).
  - Next four: 01 00 00 A5.
  - done pulse exactly 6*32 cycles after the first REQ cycle.
  - busy low after done.
- Same dump with tx_ready toggling 1-0-1-0:
  - identical byte sequence
  - tx_data never changes while tx_valid=1 and tx_ready=0
- core_rd_req held high for 10 cycles during REQ of x7:
  - rd_grant=0 throughout
  - no bytes emitted
  - dump resumes and x7 bytes are correct
- Second start pulse while busy:
  - no restart; byte count stays 128
  - exactly one done pulse
- reset asserted after 9 bytes:
  - next cycle tx_valid=0, busy=0, rd_grant=0
  - a following start produces a full, correct 128-byte dump
- FIRST_REG=5, LAST_REG=5, LSB_FIRST=0, x5=0x12345678:
  - bytes 12 34 56 78
  - then done
